// File: rtl/table_match_sequencer_pkg.sv
// rtl/table_match_sequencer_pkg.sv - shared state encoding and default sizes for the table match sequencer
package table_match_sequencer_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int DEPTH_DEF = 8;
  localparam int IDX_W_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Index width needed to address a table of the given depth.
  function automatic int idx_bits(input int depth);
    int b;
    b = 1;
    while ((1 << b) < depth) b++;
    return b;
  endfunction

endpackage

// File: rtl/table_match_sequencer_eq_compare_5b.sv
// rtl/table_match_sequencer_eq_compare_5b.sv - combinational word equality comparator (per-bit xnor, and-reduce)
module eq_compare_5b #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  logic [WIDTH-1:0] bit_eq;

  assign bit_eq = a_i ~^ b_i;
  assign eq_o   = &bit_eq;

endmodule

// File: rtl/table_match_sequencer.sv
// rtl/table_match_sequencer.sv - walks a small register table with one shared comparator,
// reporting the first valid entry equal to a latched key.
module table_match_sequencer
  import table_match_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] match_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] match_index_q, match_index_d;

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [WIDTH-1:0] cur_word;
  logic             eq;
  logic             hit;

  // Table data has no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  assign cur_word = table_q[idx_q];

  eq_compare_5b #(
    .WIDTH(WIDTH)
  ) u_eq (
    .a_i (cur_word),
    .b_i (key_q),
    .eq_o(eq)
  );

  assign hit = eq & valid_q[idx_q];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    key_d         = key_q;
    found_d       = found_q;
    match_index_d = match_index_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key;
          idx_d   = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (hit) begin
          found_d       = 1'b1;
          match_index_d = idx_q;
          state_d       = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          found_d       = 1'b0;
          match_index_d = '0;
          state_d       = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      key_q         <= '0;
      found_q       <= 1'b0;
      match_index_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      key_q         <= key_d;
      found_q       <= found_d;
      match_index_q <= match_index_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign found       = found_q;
  assign match_index = match_index_q;

endmodule
